// File: rtl/pcie_mem_req_scheduler.sv
// pcie_mem_req_scheduler: round-robin write/read DMA arbiter that emits
// 3DW PCIe MWr/MRd headers split at MPS and 4 KB, with read tag limiting.
module pcie_mem_req_scheduler #(
  parameter int MPS_BYTES = 128,
  parameter int NUM_TAGS  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                cfg_bdf,
  input  logic                       wr_req_valid,
  output logic                       wr_req_ready,
  input  logic [31:0]                wr_req_addr,
  input  logic [12:0]                wr_req_len,
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [31:0]                rd_req_addr,
  input  logic [12:0]                rd_req_len,
  output logic                       hdr_valid,
  input  logic                       hdr_ready,
  output logic [95:0]                hdr,
  output logic                       hdr_is_wr,
  output logic [12:0]                hdr_len_bytes,
  input  logic                       cpl_release,
  output logic [$clog2(NUM_TAGS):0]  outstanding_rd
);

  localparam int TW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int OW = $clog2(NUM_TAGS) + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state;
  logic          rr_last_rd;
  logic [31:0]   addr_q;
  logic [12:0]   rem_q;
  logic          wr_q;
  logic [TW-1:0] tag_q;

  logic          wr_win;
  logic          rd_win;
  logic          acc_wr;
  logic          acc_rd;
  logic          acc;
  logic          fire;
  logic          rd_fire;
  logic          rel;
  logic [OW-1:0] occ_nxt;
  logic [TW-1:0] tag_nxt;
  logic [31:0]   nxt_addr;
  logic [12:0]   nxt_rem;
  logic [31:0]   src_addr;
  logic [12:0]   src_rem;
  logic          src_wr;
  logic          try_load;
  logic [12:0]   to_4k;
  logic [12:0]   chunk;
  logic          room;
  logic          load;
  logic [95:0]   hdr_d;

  always_comb begin
    wr_win = wr_req_valid & (!rd_req_valid | rr_last_rd);
    rd_win = rd_req_valid & !wr_win;
  end

  assign wr_req_ready = rst_n & (state == IDLE) & wr_win;
  assign rd_req_ready = rst_n & (state == IDLE) & rd_win;

  assign acc_wr  = wr_req_valid & wr_req_ready;
  assign acc_rd  = rd_req_valid & rd_req_ready;
  assign acc     = acc_wr | acc_rd;
  assign fire    = hdr_valid & hdr_ready;
  assign rd_fire = fire & !hdr_is_wr;
  assign rel     = cpl_release & (outstanding_rd != '0);
  assign occ_nxt = outstanding_rd + OW'(rd_fire) - OW'(rel);
  assign tag_nxt = rd_fire ? TW'(tag_q + 1'b1) : tag_q;

  assign nxt_addr = addr_q + 32'(hdr_len_bytes);
  assign nxt_rem  = rem_q - hdr_len_bytes;

  // Next header comes from a fresh request, the post-handshake
  // remainder, or a retry of a tag-gated read.
  always_comb begin
    src_addr = addr_q;
    src_rem  = rem_q;
    src_wr   = wr_q;
    try_load = 1'b0;
    if (state == IDLE) begin
      src_addr = acc_wr ? wr_req_addr : rd_req_addr;
      src_rem  = acc_wr ? wr_req_len : rd_req_len;
      src_wr   = acc_wr;
      try_load = acc;
    end else if (fire) begin
      src_addr = nxt_addr;
      src_rem  = nxt_rem;
      try_load = 1'b1;
    end else begin
      try_load = !hdr_valid;
    end
  end

  always_comb begin
    to_4k = 13'd4096 - {1'b0, src_addr[11:0]};
    chunk = src_rem;
    if (13'(MPS_BYTES) < chunk) chunk = 13'(MPS_BYTES);
    if (to_4k < chunk) chunk = to_4k;
  end

  assign room = src_wr | (occ_nxt < OW'(NUM_TAGS));
  assign load = try_load & (src_rem != '0) & room;

  always_comb begin
    hdr_d          = '0;
    hdr_d[95:93]   = src_wr ? 3'b010 : 3'b000;
    hdr_d[73:64]   = chunk[11:2];
    hdr_d[63:48]   = cfg_bdf;
    hdr_d[47:40]   = src_wr ? 8'd0 : 8'(tag_nxt);
    hdr_d[39:36]   = (chunk == 13'd4) ? 4'h0 : 4'hF;
    hdr_d[35:32]   = 4'hF;
    hdr_d[31:2]    = src_addr[31:2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_last_rd     <= 1'b1;
      addr_q         <= '0;
      rem_q          <= '0;
      wr_q           <= 1'b0;
      tag_q          <= '0;
      outstanding_rd <= '0;
      hdr_valid      <= 1'b0;
      hdr            <= '0;
      hdr_is_wr      <= 1'b0;
      hdr_len_bytes  <= '0;
    end else begin
      outstanding_rd <= occ_nxt;
      tag_q          <= tag_nxt;
      if (acc) rr_last_rd <= acc_rd;
      if (acc | fire) begin
        addr_q <= src_addr;
        rem_q  <= src_rem;
        wr_q   <= src_wr;
      end
      if (load) begin
        hdr_valid     <= 1'b1;
        hdr           <= hdr_d;
        hdr_is_wr     <= src_wr;
        hdr_len_bytes <= chunk;
      end else if (fire) begin
        hdr_valid <= 1'b0;
      end
      unique case (state)
        IDLE:  if (acc && src_rem != '0) state <= ISSUE;
        ISSUE: if (fire && nxt_rem == '0) state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_mem_req_scheduler.sv
// tb_pcie_mem_req_scheduler: directed and randomized checks of header
// splitting, arbitration, tag gating and reset against a queue model.
module tb_pcie_mem_req_scheduler;

  localparam int MPS = 128;
  localparam int NT  = 32;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    int          c;
  } chunk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_bdf;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_req_addr;
  logic [12:0] wr_req_len;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [12:0] rd_req_len;
  logic        hdr_valid, hdr_ready;
  logic [95:0] hdr;
  logic        hdr_is_wr;
  logic [12:0] hdr_len_bytes;
  logic        cpl_release;
  logic [5:0]  outstanding_rd;

  int n_pass  = 0;
  int n_total = 0;
  int exp_tag = 0;
  int exp_out = 0;
  chunk_t q[$];

  always #5 clk = ~clk;

  pcie_mem_req_scheduler #(.MPS_BYTES(MPS), .NUM_TAGS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_bdf(cfg_bdf),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr(hdr),
    .hdr_is_wr(hdr_is_wr), .hdr_len_bytes(hdr_len_bytes),
    .cpl_release(cpl_release), .outstanding_rd(outstanding_rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [95:0] obs, logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  function automatic logic [95:0] mk_hdr(bit wr, logic [31:0] a, int c,
                                         int tag, logic [15:0] bdf);
    logic [95:0] h;
    h          = '0;
    h[95:93]   = wr ? 3'b010 : 3'b000;
    h[73:64]   = 10'((c / 4) % 1024);
    h[63:48]   = bdf;
    h[47:40]   = wr ? 8'd0 : 8'(tag);
    h[39:36]   = (c == 4) ? 4'h0 : 4'hF;
    h[35:32]   = 4'hF;
    h[31:2]    = a[31:2];
    return h;
  endfunction

  function automatic void split(bit wr, logic [31:0] a, int len);
    int rem;
    int c;
    int b;
    logic [31:0] p;
    rem = len;
    p   = a;
    while (rem > 0) begin
      b = 4096 - int'(p[11:0]);
      c = rem;
      if (c > MPS) c = MPS;
      if (c > b) c = b;
      q.push_back('{wr, p, c});
      p   = p + 32'(c);
      rem = rem - c;
    end
  endfunction

  task automatic req(bit wr, logic [31:0] a, int len);
    if (wr) begin
      wr_req_valid = 1'b1; wr_req_addr = a; wr_req_len = 13'(len);
    end else begin
      rd_req_valid = 1'b1; rd_req_addr = a; rd_req_len = 13'(len);
    end
    #1;
    for (int i = 0; i < 300 && !(wr ? wr_req_ready : rd_req_ready); i++)
      tick();
    chk("req_ready", wr ? wr_req_ready : rd_req_ready, 1);
    tick();
    if (wr) wr_req_valid = 1'b0;
    else rd_req_valid = 1'b0;
    #1;
  endtask

  task automatic expect_hdr(string name, bit wr, logic [31:0] a, int c,
                            int max_wait);
    for (int i = 0; i < max_wait && !hdr_valid; i++) tick();
    chk({name, "_valid"}, hdr_valid, 1);
    chk({name, "_hdr"}, hdr, mk_hdr(wr, a, c, exp_tag, cfg_bdf));
    chk({name, "_len"}, hdr_len_bytes, c);
    chk({name, "_iswr"}, hdr_is_wr, wr);
    hdr_ready = 1'b1;
    tick();
    if (!wr) begin
      exp_tag = (exp_tag + 1) % NT;
      exp_out++;
    end
  endtask

  task automatic release_one();
    cpl_release = 1'b1;
    tick();
    cpl_release = 1'b0;
    if (exp_out > 0) exp_out--;
  endtask

  initial begin
    chunk_t e;
    logic [95:0] held;
    logic [31:0] ra;
    bit rw;
    bit rdy;
    bit rel;
    int rl;

    rst_n = 1'b0; cfg_bdf = 16'h0100;
    wr_req_valid = 1'b1; wr_req_addr = '0; wr_req_len = 13'd4;
    rd_req_valid = 1'b1; rd_req_addr = '0; rd_req_len = 13'd4;
    hdr_ready = 1'b1; cpl_release = 1'b0;
    repeat (3) tick();
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_wr_ready", wr_req_ready, 0);
    chk("rst_rd_ready", rd_req_ready, 0);
    chk("rst_hdr", hdr, 0);
    chk("rst_iswr", hdr_is_wr, 0);
    chk("rst_lenb", hdr_len_bytes, 0);
    chk("rst_out", outstanding_rd, 0);
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // 300 B write: 32/32/11 DW, zero-length request queued behind it
    cfg_bdf = 16'(($urandom));
    wr_req_valid = 1'b1; wr_req_addr = 32'h1000; wr_req_len = 13'd300;
    #1;
    chk("w300_ready", wr_req_ready, 1);
    chk("w300_rd_ready", rd_req_ready, 0);
    tick();
    wr_req_addr = 32'h0000_2000; wr_req_len = 13'd0;
    #1;
    chk("w300_busy0", wr_req_ready, 0);
    expect_hdr("w300_c0", 1, 32'h1000, 128, 0);
    chk("w300_busy1", wr_req_ready, 0);
    expect_hdr("w300_c1", 1, 32'h1080, 128, 0);
    chk("w300_busy2", wr_req_ready, 0);
    expect_hdr("w300_c2", 1, 32'h1100, 44, 0);
    chk("w300_done_valid", hdr_valid, 0);
    chk("w300_idle_ready", wr_req_ready, 1);
    tick();
    wr_req_valid = 1'b0;
    #1;
    chk("zero_len_nohdr0", hdr_valid, 0);
    tick();
    chk("zero_len_nohdr1", hdr_valid, 0);

    // read straddling 4 KB
    req(0, 32'h0FC0, 128);
    expect_hdr("r4k_c0", 0, 32'h0FC0, 64, 0);
    expect_hdr("r4k_c1", 0, 32'h1000, 64, 0);
    chk("r4k_out", outstanding_rd, 2);
    release_one();
    release_one();
    chk("rel_out0", outstanding_rd, 0);
    release_one();
    chk("rel_at_zero", outstanding_rd, 0);

    // contention: write first, then read, then write again
    wr_req_valid = 1'b1; wr_req_addr = 32'h3000; wr_req_len = 13'd64;
    rd_req_valid = 1'b1; rd_req_addr = 32'h4000; rd_req_len = 13'd64;
    #1;
    chk("arb1_wr_ready", wr_req_ready, 1);
    chk("arb1_rd_ready", rd_req_ready, 0);
    tick();
    wr_req_valid = 1'b0;
    #1;
    chk("arb1_rd_wait", rd_req_ready, 0);
    expect_hdr("arb1_w", 1, 32'h3000, 64, 0);
    chk("arb1_rd_turn", rd_req_ready, 1);
    tick();
    rd_req_valid = 1'b0;
    expect_hdr("arb1_r", 0, 32'h4000, 64, 0);
    wr_req_valid = 1'b1; wr_req_addr = 32'h5000; wr_req_len = 13'd8;
    rd_req_valid = 1'b1; rd_req_addr = 32'h6000; rd_req_len = 13'd8;
    #1;
    chk("arb2_wr_ready", wr_req_ready, 1);
    chk("arb2_rd_ready", rd_req_ready, 0);
    tick();
    wr_req_valid = 1'b0;
    expect_hdr("arb2_w", 1, 32'h5000, 8, 0);
    chk("arb2_rd_turn", rd_req_ready, 1);
    tick();
    rd_req_valid = 1'b0;
    expect_hdr("arb2_r", 0, 32'h6000, 8, 0);
    release_one();
    release_one();
    chk("arb_out0", outstanding_rd, 0);

    // tag exhaustion: 33 single-chunk reads without completions
    for (int i = 0; i < NT; i++) begin
      ra = $urandom & 32'hFFFF_FF80;
      rl = 4 * $urandom_range(1, MPS / 4);
      req(0, ra, rl);
      expect_hdr("tag_fill", 0, ra, rl, 3);
    end
    chk("tag_full_out", outstanding_rd, NT);
    req(0, 32'h0000_8000, 16);
    for (int i = 0; i < 5; i++) begin
      chk("tag_gated", hdr_valid, 0);
      tick();
    end
    release_one();
    expect_hdr("tag_33rd", 0, 32'h0000_8000, 16, 0);
    chk("tag_33_out", outstanding_rd, NT);
    for (int i = 0; i < NT; i++) release_one();
    chk("tag_drain_out", outstanding_rd, 0);

    // stalled 4 B write: header held, bdf sampled at load
    cfg_bdf = 16'hBEEF;
    hdr_ready = 1'b0;
    req(1, 32'h7FFC, 4);
    held = mk_hdr(1, 32'h7FFC, 4, 0, 16'hBEEF);
    cfg_bdf = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", hdr_valid, 1);
      chk("hold_hdr", hdr, held);
      chk("hold_lenb", hdr_len_bytes, 4);
      tick();
    end
    hdr_ready = 1'b1;
    tick();
    chk("hold_once", hdr_valid, 0);

    // randomized transfers, random backpressure and completions
    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom);
      ra = $urandom & 32'hFFFF_FFFC;
      rl = ($urandom % 4 == 0) ? 4 * $urandom_range(0, 1024)
                               : 4 * $urandom_range(0, 80);
      cfg_bdf = 16'($urandom);
      split(rw, ra, rl);
      req(rw, ra, rl);
      for (int c = 0; c < 4000 && q.size() > 0; c++) begin
        rdy = ($urandom % 4) != 0;
        rel = ($urandom % 3) == 0;
        hdr_ready = rdy;
        cpl_release = rel;
        #1;
        if (rel && exp_out > 0) exp_out--;
        if (hdr_valid && rdy) begin
          e = q.pop_front();
          chk("rnd_hdr", hdr, mk_hdr(e.wr, e.a, e.c, exp_tag, cfg_bdf));
          chk("rnd_lenb", hdr_len_bytes, e.c);
          chk("rnd_iswr", hdr_is_wr, e.wr);
          if (!e.wr) begin
            exp_tag = (exp_tag + 1) % NT;
            exp_out++;
          end
        end
        tick();
      end
      cpl_release = 1'b0;
      hdr_ready = 1'b1;
      chk("rnd_drained", q.size(), 0);
      q.delete();
      chk("rnd_idle", hdr_valid, 0);
      chk("rnd_out", outstanding_rd, exp_out);
    end
    for (int i = 0; i < NT + 1; i++) release_one();
    chk("rnd_out0", outstanding_rd, 0);

    // reset in the middle of a 3-chunk write
    cfg_bdf = 16'h0A0B;
    req(0, 32'h0000_8800, 4);
    expect_hdr("prerst_r", 0, 32'h0000_8800, 4, 0);
    chk("prerst_out", outstanding_rd, 1);
    req(1, 32'h0000_9000, 384);
    expect_hdr("prerst_w0", 1, 32'h0000_9000, 128, 0);
    hdr_ready = 1'b0;
    chk("prerst_w1", hdr, mk_hdr(1, 32'h0000_9080, 128, 0, 16'h0A0B));
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", hdr_valid, 0);
    chk("midrst_out", outstanding_rd, 0);
    rst_n = 1'b1;
    exp_tag = 0;
    exp_out = 0;
    hdr_ready = 1'b1;
    tick();
    chk("postrst_quiet", hdr_valid, 0);
    req(0, 32'h0000_A000, 16);
    expect_hdr("postrst_r", 0, 32'h0000_A000, 16, 0);
    tick();
    chk("postrst_nomore", hdr_valid, 0);
    chk("postrst_out", outstanding_rd, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
